// File: rtl/dma_pkg.sv
// Shared encodings for the DMA handshake: mode_io values, responder FSM states
// and status-word bit offsets, common to the controller, processor model and I/O ports.
package dma_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_SRC  = 2'b01;
    localparam logic [1:0] MODE_SNK  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } dma_state_e;

    // Flag offsets above the word_count field: {ovf, unf, full, empty, word_count}
    localparam int STAT_EMPTY_OFS = 0;
    localparam int STAT_FULL_OFS  = 1;
    localparam int STAT_UNF_OFS   = 2;
    localparam int STAT_OVF_OFS   = 3;

    function automatic int status_bits(input int depth);
        return $clog2(depth) + 1 + 4;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head, occupancy count and sticky
// overflow/underflow flags. A simultaneous push and pop both take effect.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          push_drop_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          ovf_o,
    output logic          unf_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands then.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (push_i && !do_push) | push_drop_i;
        unf_d = unf_q | (pop_i && empty_o);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: rtl/dma_io_responder.sv
// I/O-port end of the DREQ/DACK handshake: buffers words in a FIFO, requests
// DMA service, moves one word per dack and answers PIO data/status cycles.
module dma_io_responder
    import dma_pkg::*;
#(
    parameter int            DW        = 8,
    parameter int            AW        = 8,
    parameter int            DEPTH     = 4,
    parameter logic [AW-1:0] BASE_ADDR = 8'h40,
    localparam int           CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode_io,
    input  logic          enable,
    input  logic          read_io,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          data_oe,
    output logic          dreq,
    input  logic          dack,
    input  logic          dev_wr,
    input  logic [DW-1:0] dev_wdata,
    input  logic          dev_rd,
    output logic [DW-1:0] dev_rdata,
    output logic [CW-1:0] word_count,
    output logic          ovf,
    output logic          unf
);

    localparam logic [AW-1:0] STAT_ADDR = BASE_ADDR + AW'(1);
    localparam int            STAT_W    = status_bits(DEPTH);

    dma_state_e    state_q;
    logic          dreq_q;

    logic [DW-1:0] fifo_rdata;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_ovf, fifo_unf;
    logic          fifo_push, fifo_pop, push_drop;
    logic [DW-1:0] fifo_wdata;

    logic          mode_src, mode_snk, mode_ready;
    logic          dma_xfer, dma_src_rd, dma_snk_wr;
    logic          pio_cycle, pio_data_wr, pio_data_rd, pio_stat_rd;
    logic          bus_push, bus_pop, head_rd, stat_rd;
    logic [DW-1:0] status_word;

    assign mode_src   = (mode_io == MODE_SRC);
    assign mode_snk   = (mode_io == MODE_SNK);
    assign mode_ready = (mode_src && !fifo_empty) || (mode_snk && !fifo_full);

    // A DMA word moves only from REQ; dack held high through ACK is just the tail of the same cycle.
    assign dma_xfer   = !rst && (state_q == ST_REQ) && dack && enable &&
                        ((mode_src && read_io) || (mode_snk && !read_io));
    assign dma_src_rd = dma_xfer && mode_src;
    assign dma_snk_wr = dma_xfer && mode_snk;

    assign pio_cycle   = !rst && enable && !dack;
    assign pio_data_wr = pio_cycle && !read_io && (addr == BASE_ADDR);
    assign pio_data_rd = pio_cycle &&  read_io && (addr == BASE_ADDR);
    assign pio_stat_rd = pio_cycle &&  read_io && (addr == STAT_ADDR);

    assign bus_push = dma_snk_wr || pio_data_wr;
    assign bus_pop  = dma_src_rd || pio_data_rd;
    assign head_rd  = bus_pop;
    assign stat_rd  = pio_stat_rd;

    // Two pushes in one cycle cannot both land: the bus word wins and the lost
    // device word is reported through ovf. Coincident pops remove a single word.
    assign fifo_push  = !rst && (bus_push || dev_wr);
    assign fifo_wdata = bus_push ? data_in : dev_wdata;
    assign push_drop  = bus_push && dev_wr;
    assign fifo_pop   = !rst && (bus_pop || dev_rd);

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .wdata_i     (fifo_wdata),
        .push_drop_i (push_drop),
        .pop_i       (fifo_pop),
        .rdata_o     (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .ovf_o       (fifo_ovf),
        .unf_o       (fifo_unf)
    );

    always_comb begin
        status_word = '0;
        status_word[CW-1:0]                 = fifo_count;
        status_word[CW + STAT_EMPTY_OFS]    = fifo_empty;
        status_word[CW + STAT_FULL_OFS]     = fifo_full;
        status_word[CW + STAT_UNF_OFS]      = fifo_unf;
        status_word[CW + STAT_OVF_OFS]      = fifo_ovf;
    end

    always_comb begin
        data_out = '0;
        if (head_rd) begin
            data_out = fifo_empty ? '0 : fifo_rdata;
        end else if (stat_rd) begin
            data_out = status_word;
        end
    end

    assign data_oe = head_rd || stat_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dreq_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mode_ready) begin
                        state_q <= ST_REQ;
                        dreq_q  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (dma_xfer) begin
                        state_q <= ST_ACK;
                        dreq_q  <= 1'b0;
                    end else if (!mode_ready) begin
                        state_q <= ST_IDLE;
                        dreq_q  <= 1'b0;
                    end
                end
                ST_ACK: begin
                    dreq_q <= 1'b0;
                    if (!dack) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    dreq_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dreq       = dreq_q;
    assign dev_rdata  = fifo_rdata;
    assign word_count = fifo_count;
    assign ovf        = fifo_ovf;
    assign unf        = fifo_unf;

    // Status word must fit the data bus; STAT_W is referenced so a too-narrow DW shows up in review.
    logic unused_stat_w;
    assign unused_stat_w = (STAT_W > DW);

endmodule

// File: tb/tb_dma_io_responder.sv
// Directed bench for dma_io_responder: stimulus pushes expected bus/device read
// data into queues that a negedge monitor pops; state is checked inline.
module tb_dma_io_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode_io;
    logic       enable, read_io, dack, dev_wr, dev_rd;
    logic [7:0] addr, data_in, dev_wdata;
    logic [7:0] data_out, dev_rdata;
    logic       data_oe, dreq, ovf, unf;
    logic [2:0] word_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] dev_q[$];

    always #5 clk = ~clk;

    dma_io_responder #(
        .DW(8), .AW(8), .DEPTH(4), .BASE_ADDR(8'h40)
    ) dut (
        .clk(clk), .rst(rst), .mode_io(mode_io), .enable(enable), .read_io(read_io),
        .addr(addr), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .dreq(dreq), .dack(dack), .dev_wr(dev_wr), .dev_wdata(dev_wdata),
        .dev_rd(dev_rd), .dev_rdata(dev_rdata), .word_count(word_count),
        .ovf(ovf), .unf(unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        enable = 0; read_io = 0; dack = 0; addr = 8'h00; data_in = 8'h00;
        dev_wr = 0; dev_rd = 0; dev_wdata = 8'h00;
    endtask

    // Monitor: every bus read served must match the head of exp_q; device pops match dev_q.
    always @(negedge clk) begin
        if (data_oe === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bus_read: unexpected data_oe, got 0x%0h expected no read", data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_fail++;
                    $display("FAIL bus_read: got 0x%0h expected 0x%0h at %0t", data_out, e, $time);
                end else begin
                    $display("ok   bus_read: 0x%0h", data_out);
                end
            end
        end else begin
            n_checks++;
            if (data_out !== 8'h00) begin
                n_fail++;
                $display("FAIL idle_data_out: got 0x%0h expected 0x00 at %0t", data_out, $time);
            end
        end
        if (dev_rd === 1'b1) begin
            n_checks++;
            if (dev_q.size() == 0) begin
                n_fail++;
                $display("FAIL dev_read: unexpected dev_rd, got 0x%0h expected none", dev_rdata);
            end else begin
                logic [7:0] e;
                e = dev_q.pop_front();
                if (dev_rdata !== e) begin
                    n_fail++;
                    $display("FAIL dev_read: got 0x%0h expected 0x%0h at %0t", dev_rdata, e, $time);
                end else begin
                    $display("ok   dev_read: 0x%0h", dev_rdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; mode_io = 2'b00;
        idle_bus();
        repeat (3) tick();
        rst = 0;
        chk("reset_dreq", dreq, 0);
        chk("reset_count", word_count, 0);
        chk("reset_oe", data_oe, 0);
        chk("reset_flags", {ovf, unf}, 0);

        // 1 Source mode
        mode_io = 2'b01; dev_wr = 1; dev_wdata = 8'h11;
        tick();
        chk("src_dreq_wait", dreq, 0);
        dev_wdata = 8'h22;
        tick();
        dev_wr = 0;
        chk("src_dreq_up", dreq, 1);
        chk("src_count2", word_count, 2);
        exp_q.push_back(8'h11);
        dack = 1; enable = 1; read_io = 1;
        tick();
        chk("src_dreq_low_ack", dreq, 0);
        chk("src_count1", word_count, 1);
        #1;
        chk("src_ack_hold_oe", data_oe, 0);
        dack = 0; enable = 0; read_io = 0;
        tick();
        chk("src_ack_to_idle", dreq, 0);
        tick();
        chk("src_rerequest", dreq, 1);
        exp_q.push_back(8'h22);
        dack = 1; enable = 1; read_io = 1;
        tick();
        dack = 0; enable = 0; read_io = 0;
        chk("src_count0", word_count, 0);
        repeat (3) tick();
        chk("src_no_req_empty", dreq, 0);

        // 2 Sink mode
        mode_io = 2'b10;
        tick();
        chk("snk_dreq_up", dreq, 1);
        for (int i = 0; i < 4; i++) begin
            dack = 1; enable = 1; read_io = 0; data_in = 8'hA0 + 8'(i);
            tick();
            dack = 0; enable = 0; data_in = 8'h00;
            chk("snk_count", word_count, i + 1);
            chk("snk_dreq_ack", dreq, 0);
            tick();
            if (i < 3) begin
                tick();
                chk("snk_dreq_again", dreq, 1);
            end
        end
        tick();
        chk("snk_full_no_req", dreq, 0);
        for (int i = 0; i < 4; i++) dev_q.push_back(8'hA0 + 8'(i));
        dev_rd = 1;
        tick();
        chk("snk_drain_dreq_lat", dreq, 0);
        tick();
        chk("snk_drain_dreq_up", dreq, 1);
        tick();
        tick();
        dev_rd = 0;
        chk("snk_drained", word_count, 0);
        mode_io = 2'b00;
        tick();
        chk("snk_mode_off", dreq, 0);

        // 3 PIO
        enable = 1; read_io = 0; addr = 8'h40; data_in = 8'h28;
        tick();
        chk("pio_count1", word_count, 1);
        exp_q.push_back(8'h01);
        read_io = 1; addr = 8'h41; data_in = 8'h00;
        tick();
        exp_q.push_back(8'h28);
        addr = 8'h40;
        tick();
        exp_q.push_back(8'h00);
        tick();
        chk("pio_unf", unf, 1);
        chk("pio_count0", word_count, 0);
        exp_q.push_back(8'h28);
        addr = 8'h41;
        tick();
        addr = 8'h42;
        #1;
        chk("pio_other_addr_oe", data_oe, 0);
        tick();
        idle_bus();

        // 4 Overflow and simultaneous push/pop
        dev_wr = 1;
        for (int i = 1; i <= 4; i++) begin
            dev_wdata = 8'(i);
            tick();
        end
        chk("ovf_fill4", word_count, 4);
        chk("ovf_before", ovf, 0);
        dev_wdata = 8'h05;
        tick();
        dev_wr = 0;
        chk("ovf_set", ovf, 1);
        chk("ovf_count4", word_count, 4);
        dev_q.push_back(8'h01);
        dev_q.push_back(8'h02);
        dev_rd = 1;
        tick();
        tick();
        dev_rd = 0;
        chk("sim_count2", word_count, 2);
        mode_io = 2'b01;
        tick();
        chk("sim_dreq", dreq, 1);
        exp_q.push_back(8'h03);
        dack = 1; enable = 1; read_io = 1; dev_wr = 1; dev_wdata = 8'h66;
        tick();
        idle_bus();
        chk("sim_count_same", word_count, 2);
        dev_q.push_back(8'h04);
        dev_q.push_back(8'h66);
        dev_rd = 1;
        tick();
        tick();
        dev_rd = 0;
        chk("sim_drained", word_count, 0);
        tick();
        tick();

        // 5 Reset mid-transfer
        dev_wr = 1; dev_wdata = 8'h77;
        tick();
        dev_wr = 0;
        tick();
        chk("rst_pre_dreq", dreq, 1);
        rst = 1; dack = 1; enable = 1; read_io = 1;
        #1;
        chk("rst_cycle_oe", data_oe, 0);
        tick();
        rst = 0;
        idle_bus();
        chk("rst_dreq", dreq, 0);
        chk("rst_count", word_count, 0);
        chk("rst_flags", {ovf, unf}, 0);
        #1;
        chk("rst_oe", data_oe, 0);

        // 6 Wrong direction
        dev_wr = 1; dev_wdata = 8'h99;
        tick();
        dev_wr = 0;
        tick();
        chk("wd_dreq", dreq, 1);
        dack = 1; enable = 1; read_io = 0;
        #1;
        chk("wd_oe", data_oe, 0);
        tick();
        chk("wd_dreq_held", dreq, 1);
        chk("wd_no_pop", word_count, 1);
        tick();
        chk("wd_dreq_held2", dreq, 1);
        exp_q.push_back(8'h99);
        read_io = 1;
        tick();
        idle_bus();
        chk("wd_final_count", word_count, 0);
        mode_io = 2'b00;
        repeat (3) tick();

        chk("exp_q_empty", exp_q.size(), 0);
        chk("dev_q_empty", dev_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
